// File: rtl/mac_join_accum_pkg.sv
// Shared constants and fixed-point helpers for the mac_join_accum frame reducer.
// Helpers work on a wide signed container; callers pass the real accumulator width.
package mac_join_accum_pkg;

  localparam int MAX_W = 128;

  localparam logic REDUCE_SUM = 1'b0;
  localparam logic REDUCE_MAX = 1'b1;

  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_e;

  // Most-negative value of an acc_w-bit signed number, sign-extended to MAX_W.
  function automatic logic [MAX_W-1:0] acc_min(input int acc_w);
    return ~((MAX_W'(1) << (acc_w - 1)) - MAX_W'(1));
  endfunction

  // Signed add clipped to the acc_w range; returns {clip, sum} with sum sign-extended.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int acc_w);
    logic signed [MAX_W-1:0] s;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic                    clip;
    s    = $signed(a) + $signed(b);
    hi   = $signed((MAX_W'(1) << (acc_w - 1)) - MAX_W'(1));
    lo   = $signed(acc_min(acc_w));
    clip = 1'b0;
    if (s > hi) begin
      s    = hi;
      clip = 1'b1;
    end else if (s < lo) begin
      s    = lo;
      clip = 1'b1;
    end
    return {clip, s};
  endfunction

endpackage

// File: rtl/mac_join_accum_if.sv
// Stream bundle for mac_join_accum: vinput, M_row and beta channels plus frame-state debug.
interface mac_join_accum_if
  import mac_join_accum_pkg::*;
#(
  parameter int A      = 2,
  parameter int DATA_W = 64,
  parameter int ACC_W  = 72
);
  logic [DATA_W-1:0]  vin_tdata;
  logic               vin_tvalid;
  logic               vin_tready;
  logic [A-1:0]       m_tdata;
  logic               m_tlast;
  logic               m_tvalid;
  logic               m_tready;
  logic               mode_max;
  logic [A*ACC_W-1:0] beta_tdata;
  logic [A-1:0]       beta_ovf;
  logic               beta_tvalid;
  logic               beta_tready;
  frame_state_e       dbg_state;

  modport master (
    output vin_tdata, vin_tvalid, m_tdata, m_tlast, m_tvalid, mode_max, beta_tready,
    input  vin_tready, m_tready, beta_tdata, beta_ovf, beta_tvalid, dbg_state
  );

  modport slave (
    input  vin_tdata, vin_tvalid, m_tdata, m_tlast, m_tvalid, mode_max, beta_tready,
    output vin_tready, m_tready, beta_tdata, beta_ovf, beta_tvalid, dbg_state
  );
endinterface

// File: rtl/mac_join_accum_fifo.sv
// Synchronous FIFO with asynchronous active-high reset; head word is read from registered storage,
// so a push in cycle n is visible at dout in cycle n+1.
module sync_fifo_ah #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mac_join_accum.sv
// Joins vinput words with A-lane M_row masks and reduces each tlast-closed frame into A
// saturating sum or max results, held in a ready/valid output register.
module mac_join_accum
  import mac_join_accum_pkg::*;
#(
  parameter int A         = 2,
  parameter int DATA_W    = 64,
  parameter int ACC_W     = 72,
  parameter int VIN_DEPTH = 8,
  parameter int M_DEPTH   = 128
) (
  input  logic             clk,
  input  logic             rst,
  mac_join_accum_if.slave  bus
);
  // Handshake: a beat transfers on a rising edge where tvalid && tready are both high; a source
  // holds tvalid and data stable until that edge, and tready may rise or fall freely.

  logic              rdy_en;
  logic              vin_full, vin_empty, m_full, m_empty;
  logic              vin_push, m_push;
  logic [DATA_W-1:0] vin_head;
  logic [A:0]        m_head;
  logic [A-1:0]      head_bits;
  logic              head_last;
  logic              fire;
  logic              beta_valid_q;
  frame_state_e      state_q;
  logic              mode_q;
  logic              frame_start;
  logic              cur_mode;
  logic [MAX_W-1:0]  vin_ext;
  logic [ACC_W-1:0]  lane_res [A];
  logic              lane_ovf [A];
  logic [A*ACC_W-1:0] beta_data;
  logic [A-1:0]      beta_ovf_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  assign bus.vin_tready = rdy_en && !vin_full;
  assign bus.m_tready   = rdy_en && !m_full;
  assign vin_push       = bus.vin_tvalid && bus.vin_tready;
  assign m_push         = bus.m_tvalid && bus.m_tready;

  sync_fifo_ah #(.DATA_W(DATA_W), .DEPTH(VIN_DEPTH)) u_vin_fifo (
    .clk(clk), .rst(rst), .push(vin_push), .din(bus.vin_tdata), .pop(fire),
    .dout(vin_head), .full(vin_full), .empty(vin_empty)
  );

  sync_fifo_ah #(.DATA_W(A+1), .DEPTH(M_DEPTH)) u_m_fifo (
    .clk(clk), .rst(rst), .push(m_push), .din({bus.m_tlast, bus.m_tdata}), .pop(fire),
    .dout(m_head), .full(m_full), .empty(m_empty)
  );

  assign head_bits = m_head[A-1:0];
  assign head_last = m_head[A];

  // Only a closing beat needs the result register; all other beats flow regardless of output.
  assign fire = !vin_empty && !m_empty && (!head_last || !beta_valid_q || bus.beta_tready);

  assign frame_start = (state_q == FRAME_IDLE);
  assign cur_mode    = frame_start ? bus.mode_max : mode_q;
  assign vin_ext     = MAX_W'($signed(vin_head));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FRAME_IDLE;
      mode_q       <= REDUCE_SUM;
      beta_valid_q <= 1'b0;
    end else begin
      if (fire) begin
        if (frame_start) mode_q <= bus.mode_max;
        state_q <= head_last ? FRAME_IDLE : FRAME_ACTIVE;
      end
      if (fire && head_last)     beta_valid_q <= 1'b1;
      else if (bus.beta_tready)  beta_valid_q <= 1'b0;
    end
  end

  for (genvar a = 0; a < A; a++) begin : g_lane
    logic [ACC_W-1:0]       acc_q;
    logic                   ovf_q;
    logic [ACC_W-1:0]       res_q;
    logic                   res_ovf_q;
    logic [MAX_W-1:0]       acc_cur;
    logic                   ovf_cur;
    logic                   add_clip;
    logic [MAX_W-ACC_W-1:0] add_hi_unused;
    logic [ACC_W-1:0]       add_lo;
    logic [ACC_W-1:0]       acc_nxt;
    logic                   ovf_nxt;

    // The first beat of a frame starts from the seed rather than the stored accumulator.
    always_comb begin
      if (frame_start)
        acc_cur = (cur_mode == REDUCE_MAX) ? acc_min(ACC_W) : '0;
      else
        acc_cur = MAX_W'($signed(acc_q));
      ovf_cur = frame_start ? 1'b0 : ovf_q;
      {add_clip, add_hi_unused, add_lo} = sat_add(acc_cur, vin_ext, ACC_W);
      acc_nxt = acc_cur[ACC_W-1:0];
      ovf_nxt = ovf_cur;
      if (head_bits[a]) begin
        if (cur_mode == REDUCE_MAX) begin
          if ($signed(vin_ext) > $signed(acc_cur)) acc_nxt = vin_ext[ACC_W-1:0];
        end else begin
          acc_nxt = add_lo;
          ovf_nxt = ovf_cur | add_clip;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q     <= '0;
        ovf_q     <= 1'b0;
        res_q     <= '0;
        res_ovf_q <= 1'b0;
      end else if (fire) begin
        if (head_last) begin
          res_q     <= acc_nxt;
          res_ovf_q <= ovf_nxt;
          acc_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          acc_q <= acc_nxt;
          ovf_q <= ovf_nxt;
        end
      end
    end

    assign lane_res[a] = res_q;
    assign lane_ovf[a] = res_ovf_q;
  end

  always_comb begin
    beta_data     = '0;
    beta_ovf_bits = '0;
    for (int a = 0; a < A; a++) begin
      beta_data[a*ACC_W +: ACC_W] = lane_res[a];
      beta_ovf_bits[a]            = lane_ovf[a];
    end
  end

  assign bus.beta_tdata  = beta_data;
  assign bus.beta_ovf    = beta_ovf_bits;
  assign bus.beta_tvalid = beta_valid_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_mac_join_accum.sv
// Directed plus randomized bench for mac_join_accum with a frame-level arithmetic reference model.
module tb_mac_join_accum;
  import mac_join_accum_pkg::*;

  localparam int A         = 2;
  localparam int DATA_W    = 8;
  localparam int ACC_W     = 8;
  localparam int VIN_DEPTH = 8;
  localparam int M_DEPTH   = 16;
  localparam int EXPW      = A*ACC_W + A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_join_accum_if #(.A(A), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  mac_join_accum #(
    .A(A), .DATA_W(DATA_W), .ACC_W(ACC_W), .VIN_DEPTH(VIN_DEPTH), .M_DEPTH(M_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int                        n_checks = 0;
  int                        n_pass   = 0;
  logic [EXPW-1:0]           exp_q[$];
  bit                        rnd_ready = 1'b0;
  logic signed [DATA_W-1:0]  fr_v [32];
  logic [A-1:0]              fr_m [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Reference: each frame reduced lane by lane with plain integer arithmetic.
  function automatic logic [EXPW-1:0] model_frame(input int first, input int n, input bit mx);
    logic [EXPW-1:0] r;
    longint amax, amin, acc, v, s;
    bit ovf;
    r    = '0;
    amax = (longint'(1) <<< (ACC_W-1)) - 1;
    amin = -amax - 1;
    for (int a = 0; a < A; a++) begin
      acc = mx ? amin : 0;
      ovf = 1'b0;
      for (int i = first; i < first + n; i++) begin
        if (fr_m[i][a]) begin
          v = longint'(fr_v[i]);
          if (mx) begin
            if (v > acc) acc = v;
          end else begin
            s = acc + v;
            if (s > amax) begin s = amax; ovf = 1'b1; end
            if (s < amin) begin s = amin; ovf = 1'b1; end
            acc = s;
          end
        end
      end
      r[a*ACC_W +: ACC_W] = acc[ACC_W-1:0];
      r[A*ACC_W + a]      = ovf;
    end
    return r;
  endfunction

  function automatic logic [EXPW-1:0] pack_exp(input int l0, input int l1, input int ovf);
    return {A'(ovf), ACC_W'(l1), ACC_W'(l0)};
  endfunction

  // Monitor: every accepted beta must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [EXPW-1:0] e;
    if (!rst && bus.beta_tvalid && bus.beta_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $error("FAIL beta_unexpected observed=%0h expected=none", bus.beta_tdata);
      end else begin
        e = exp_q.pop_front();
        check("beta_tdata", 64'(bus.beta_tdata), 64'(e[A*ACC_W-1:0]));
        check("beta_ovf",   64'(bus.beta_ovf),   64'(e[EXPW-1:A*ACC_W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.beta_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_beat(input int i, input int v, input int m);
    fr_v[i] = DATA_W'(v);
    fr_m[i] = A'(m);
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] v, input logic [A-1:0] m, input bit last);
    bit v_done, m_done, v_acc, m_acc;
    int budget;
    v_done = 1'b0; m_done = 1'b0; budget = 0;
    bus.vin_tdata = v; bus.vin_tvalid = 1'b1;
    bus.m_tdata = m; bus.m_tlast = last; bus.m_tvalid = 1'b1;
    while (!(v_done && m_done)) begin
      @(negedge clk);
      v_acc = bus.vin_tvalid && bus.vin_tready;
      m_acc = bus.m_tvalid && bus.m_tready;
      tick();
      if (v_acc) begin v_done = 1'b1; bus.vin_tvalid = 1'b0; end
      if (m_acc) begin m_done = 1'b1; bus.m_tvalid = 1'b0; end
      budget++;
      if (budget > 300) begin
        fail_now("send_beat");
        bus.vin_tvalid = 1'b0; bus.m_tvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_frame_beats(input int first, input int n, input bit mx);
    bus.mode_max = mx;
    for (int i = first; i < first + n; i++) send_beat(fr_v[i], fr_m[i], i == first + n - 1);
  endtask

  task automatic wait_drain(input string tag);
    int b;
    b = 0;
    if (!rnd_ready) bus.beta_tready = 1'b1;
    while ((exp_q.size() != 0 || bus.beta_tvalid) && b < 400) begin
      tick();
      b++;
    end
    if (b >= 400) fail_now(tag);
  endtask

  // Global time bound in case a handshake never completes.
  initial begin
    #800000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int kv, km, k, cnt, first_c, last_c, prev_mode, n, mx;
    bit va, ma;
    bus.vin_tdata = '0; bus.vin_tvalid = 1'b0;
    bus.m_tdata = '0; bus.m_tlast = 1'b0; bus.m_tvalid = 1'b0;
    bus.mode_max = 1'b0; bus.beta_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_beta_tvalid", 64'(bus.beta_tvalid), 64'(0));
    check("rst_beta_tdata",  64'(bus.beta_tdata),  64'(0));
    check("rst_beta_ovf",    64'(bus.beta_ovf),    64'(0));
    check("rst_vin_tready",  64'(bus.vin_tready),  64'(0));
    check("rst_m_tready",    64'(bus.m_tready),    64'(0));
    rst = 1'b0;
    #1;
    check("rel_vin_tready_before_clk", 64'(bus.vin_tready), 64'(0));
    tick();
    check("rel_vin_tready", 64'(bus.vin_tready), 64'(1));
    check("rel_m_tready",   64'(bus.m_tready),   64'(1));
    check("rel_dbg_state",  64'(bus.dbg_state),  64'(FRAME_IDLE));
    bus.beta_tready = 1'b1;

    // Masked sum: 5,-3,7 with masks 11,01,10
    set_beat(0, 5, 3); set_beat(1, -3, 1); set_beat(2, 7, 2);
    exp_q.push_back(pack_exp(2, 12, 0));
    send_frame_beats(0, 3, 1'b0);
    wait_drain("drain_sum");

    // Masked max on the same data, then an all-zero mask frame
    exp_q.push_back(pack_exp(5, 7, 0));
    send_frame_beats(0, 3, 1'b1);
    set_beat(3, 50, 0); set_beat(4, -20, 0);
    exp_q.push_back(pack_exp(-128, -128, 0));
    send_frame_beats(3, 2, 1'b1);
    wait_drain("drain_max");

    // Saturation on lane 0, then a clean frame clears the flag
    set_beat(0, 100, 1); set_beat(1, 100, 1);
    exp_q.push_back(pack_exp(127, 0, 1));
    send_frame_beats(0, 2, 1'b0);
    set_beat(2, 1, 1);
    exp_q.push_back(pack_exp(1, 0, 0));
    send_frame_beats(2, 1, 1'b0);
    set_beat(3, -100, 2); set_beat(4, -100, 2);
    exp_q.push_back(pack_exp(0, -128, 2));
    send_frame_beats(3, 2, 1'b0);
    wait_drain("drain_sat");

    // Minimum latency: accept at n, beta_tvalid visible in n+2
    set_beat(0, 9, 3);
    exp_q.push_back(pack_exp(9, 9, 0));
    bus.vin_tdata = fr_v[0]; bus.vin_tvalid = 1'b1;
    bus.m_tdata = fr_m[0]; bus.m_tlast = 1'b1; bus.m_tvalid = 1'b1;
    @(negedge clk);
    check("lat_accept", 64'(bus.vin_tready && bus.m_tready), 64'(1));
    tick();
    bus.vin_tvalid = 1'b0; bus.m_tvalid = 1'b0;
    check("lat_n1_tvalid", 64'(bus.beta_tvalid), 64'(0));
    tick();
    check("lat_n2_tvalid", 64'(bus.beta_tvalid), 64'(1));
    wait_drain("drain_lat");

    // Backpressure: single-beat frames while the consumer is stalled
    bus.beta_tready = 1'b0;
    bus.mode_max = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_beat(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      exp_q.push_back(model_frame(i, 1, 1'b0));
    end
    kv = 0; km = 0;
    for (int c = 0; c < 20; c++) begin
      bus.vin_tvalid = (kv < 20); bus.vin_tdata = fr_v[kv % 20];
      bus.m_tvalid = (km < 20); bus.m_tdata = fr_m[km % 20]; bus.m_tlast = 1'b1;
      @(negedge clk);
      va = bus.vin_tvalid && bus.vin_tready;
      ma = bus.m_tvalid && bus.m_tready;
      tick();
      if (va) kv++;
      if (ma) km++;
    end
    check("bp_vin_accepted", 64'(kv), 64'(VIN_DEPTH + 1));
    check("bp_m_accepted",   64'(km), 64'(M_DEPTH + 1));
    check("bp_vin_tready",   64'(bus.vin_tready),  64'(0));
    check("bp_m_tready",     64'(bus.m_tready),    64'(0));
    check("bp_beta_held",    64'(bus.beta_tvalid), 64'(1));
    bus.beta_tready = 1'b1;
    k = 0;
    while ((kv < 20 || km < 20) && k < 200) begin
      bus.vin_tvalid = (kv < 20); bus.vin_tdata = fr_v[kv % 20];
      bus.m_tvalid = (km < 20); bus.m_tdata = fr_m[km % 20]; bus.m_tlast = 1'b1;
      @(negedge clk);
      va = bus.vin_tvalid && bus.vin_tready;
      ma = bus.m_tvalid && bus.m_tready;
      tick();
      if (va) kv++;
      if (ma) km++;
      k++;
    end
    bus.vin_tvalid = 1'b0; bus.m_tvalid = 1'b0;
    if (k >= 200) fail_now("bp_refill");
    wait_drain("drain_bp");

    // Back-to-back single-beat frames: one result per cycle, no gaps
    for (int i = 0; i < 20; i++) begin
      set_beat(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      exp_q.push_back(model_frame(i, 1, 1'b0));
    end
    k = 0; cnt = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 26; c++) begin
      bus.vin_tvalid = (k < 20); bus.vin_tdata = fr_v[k % 20];
      bus.m_tvalid = (k < 20); bus.m_tdata = fr_m[k % 20]; bus.m_tlast = 1'b1;
      @(negedge clk);
      va = bus.vin_tvalid && bus.vin_tready && bus.m_tready;
      if (bus.beta_tvalid) begin
        cnt++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
      if (va) k++;
    end
    bus.vin_tvalid = 1'b0; bus.m_tvalid = 1'b0;
    check("b2b_accepted", 64'(k), 64'(20));
    check("b2b_results",  64'(cnt), 64'(20));
    check("b2b_span",     64'(last_c - first_c + 1), 64'(20));
    wait_drain("drain_b2b");

    // Reset in the middle of a frame discards the partial accumulation
    set_beat(0, 40, 3); set_beat(1, 41, 3);
    send_beat(fr_v[0], fr_m[0], 1'b0);
    send_beat(fr_v[1], fr_m[1], 1'b0);
    tick(); tick();
    check("midrst_no_beta", 64'(bus.beta_tvalid), 64'(0));
    rst = 1'b1;
    tick();
    check("midrst_beta_tvalid", 64'(bus.beta_tvalid), 64'(0));
    check("midrst_vin_tready",  64'(bus.vin_tready),  64'(0));
    rst = 1'b0;
    tick(); tick();
    check("midrst_dbg_state", 64'(bus.dbg_state), 64'(FRAME_IDLE));
    set_beat(0, 10, 3); set_beat(1, 20, 3); set_beat(2, 30, 1); set_beat(3, -5, 3);
    exp_q.push_back(pack_exp(55, 25, 0));
    send_frame_beats(0, 4, 1'b0);
    wait_drain("drain_midrst");

    // Random frames with random consumer stalls
    rnd_ready = 1'b1;
    prev_mode = 0;
    for (int f = 0; f < 30; f++) begin
      n  = int'($urandom_range(1, 4));
      mx = int'($urandom_range(0, 1));
      if (mx != prev_mode) wait_drain("drain_mode");
      prev_mode = mx;
      for (int i = 0; i < n; i++)
        set_beat(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      exp_q.push_back(model_frame(0, n, 1'(mx)));
      send_frame_beats(0, n, 1'(mx));
    end
    wait_drain("drain_rand");
    rnd_ready = 1'b0;
    bus.beta_tready = 1'b1;
    tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
